// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select
// encodings (also used by the Control_Unit), the default bubble word and
// the fetch FSM state type.
package if_fetch_stage_pkg;

  // Next-PC select encodings driven by decode
  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target (bpc)
  localparam logic [1:0] PCSRC_RA  = 2'b10;  // register target (jr)
  localparam logic [1:0] PCSRC_JMP = 2'b11;  // jump target (jpc)

  // Instruction word used as a bubble in IF/ID
  localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;

  // FETCH: request outstanding; HOLD: word captured while decode is stalled
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_next_pc_mux.sv
// Combinational next-PC selector: picks pc+4, branch, register or jump
// target from the 2-bit pcsource code. Kept standalone so branch
// prediction logic can reuse it.
module next_pc_mux
  import if_fetch_stage_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] bpc,
  input  logic [31:0] ra,
  input  logic [31:0] jpc,
  output logic [31:0] next_pc
);

  // Select the next fetch address
  always_comb begin
    next_pc = pc_plus4;
    case (pcsource)
      PCSRC_SEQ: next_pc = pc_plus4;
      PCSRC_BR:  next_pc = bpc;
      PCSRC_RA:  next_pc = ra;
      PCSRC_JMP: next_pc = jpc;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, a single-port instruction-memory
// request/ready handshake and the IF/ID register (pc4, inst, if_valid).
// A word returned while decode is stalled is parked in a hold buffer and
// delivered when the stall drops. Redirects seen while a fetch is still
// waiting on memory are remembered and the stale word is discarded.
// Optional macro IF_FETCH_STATS_EN adds fetch_cnt / stall_cnt counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = NOP_INST_WORD,
  parameter int          DELAY_SLOT = 0
)
(
`ifdef IF_FETCH_STATS_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        if_valid
);

  localparam bit KEEP_SLOT = (DELAY_SLOT != 0);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] hold_buf;
  logic [31:0] pend_target;
  logic        redirect_pend;

  logic        in_fetch;
  logic        redirect;
  logic        ret;
  logic [31:0] ret_data;
  logic        load_valid;

  assign in_fetch  = (state == FETCH);
  assign pc_plus4  = pc + 32'd4;
  assign redirect  = (pcsource != PCSRC_SEQ) && !stall;
  // A word is consumed either straight from memory or from the hold buffer
  assign ret       = !stall && (in_fetch ? imem_rdy : 1'b1);
  assign ret_data  = in_fetch ? imem_data : hold_buf;
  assign imem_addr = pc;
  // True when this cycle writes a real instruction into IF/ID
  assign load_valid = ret && !redirect_pend && (!redirect || KEEP_SLOT);

  next_pc_mux u_next_pc_mux (
    .pcsource (pcsource),
    .pc_plus4 (pc_plus4),
    .bpc      (bpc),
    .ra       (ra),
    .jpc      (jpc),
    .next_pc  (next_pc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) state <= FETCH;
    else      state <= state_next;
  end

  // FSM next state: park a returned word while stalled, resume on release
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_rdy && stall) state_next = HOLD;
      HOLD:    if (!stall)            state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // FSM outputs: request only in FETCH and never while reset is held
  always_comb begin
    imem_req = 1'b0;
    if (state == FETCH && !clrn) imem_req = 1'b1;
  end

  // PC, IF/ID, hold buffer and pending-redirect bookkeeping
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      pc            <= RESET_PC;
      pc4           <= 32'h0000_0000;
      inst          <= NOP_INST;
      if_valid      <= 1'b0;
      hold_buf      <= 32'h0000_0000;
      pend_target   <= 32'h0000_0000;
      redirect_pend <= 1'b0;
    end else begin
      if (in_fetch && imem_rdy && stall) hold_buf <= imem_data;

      if (ret) begin
        if (redirect_pend) begin
          // Word belongs to the abandoned path; a fresh redirect beats the old one
          pc            <= redirect ? next_pc : pend_target;
          redirect_pend <= 1'b0;
          inst          <= NOP_INST;
          if_valid      <= 1'b0;
        end else if (redirect && !KEEP_SLOT) begin
          pc       <= next_pc;
          inst     <= NOP_INST;
          if_valid <= 1'b0;
        end else begin
          // Sequential load, or delay-slot load on a redirect
          pc       <= next_pc;
          pc4      <= pc_plus4;
          inst     <= ret_data;
          if_valid <= 1'b1;
        end
      end else if (in_fetch && !imem_rdy && redirect) begin
        // In-flight address stays put; remember where to go afterwards
        pend_target   <= next_pc;
        redirect_pend <= 1'b1;
      end
    end
  end

`ifdef IF_FETCH_STATS_EN
  // Performance counters: valid IF/ID loads and stalled/waiting cycles
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      fetch_cnt <= 32'h0000_0000;
      stall_cnt <= 32'h0000_0000;
    end else begin
      if (load_valid)                       fetch_cnt <= fetch_cnt + 32'd1;
      if (stall || (in_fetch && !imem_rdy)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. It is the consumer of the next-PC selection produced by decode: pcsource, bpc, jpc and the register target.
- Owns the PC register and a single-port instruction-memory request/ready handshake.
- Owns the IF/ID pipeline register (pc4, inst, valid) that feeds decode.
- Handles decode stalls, redirect flushes and memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word injected as a bubble on flush.
- DELAY_SLOT, 0. When 1, the instruction fetched in the redirect cycle is kept. When 0, it is squashed.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- clrn  in  1  reset, asynchronous, active-high (asserted = 1).
- stall  in  1  decode/hazard stall; hold PC and IF/ID.
- pcsource  in  2  next-PC select: 00 = pc+4, 01 = bpc, 10 = ra, 11 = jpc.
- bpc  in  32  branch target from decode.
- jpc  in  32  jump target from decode.
- ra  in  32  register jump target (jr).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (word aligned; bits [1:0] = 00).
- imem_rdy  in  1  memory returns imem_data this cycle.
- imem_data  in  32  fetched instruction word.
- pc4  out  32  IF/ID: address of the fetched instruction + 4.
- inst  out  32  IF/ID: instruction word.
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
Reset (clrn = 1, asynchronous):
- pc = RESET_PC, pc4 = 0, inst = NOP_INST, if_valid = 0.
- State = FETCH, redirect_pend = 0, imem_req = 0 while reset is asserted.
- First request is issued in the first cycle after deassertion.

Address and arithmetic:
- imem_addr = pc.
- pc+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Redirect:
- redirect = (pcsource != 00) && !stall.
- target = bpc / ra / jpc according to pcsource.

FSM, FETCH (imem_req = 1):
- imem_rdy = 1 and stall = 0, no redirect, no redirect_pend:
  - pc <= pc+4; pc4 <= pc+4; inst <= imem_data; if_valid <= 1.
- imem_rdy = 1 and stall = 0, redirect:
  - pc <= target.
  - DELAY_SLOT = 0: inst <= NOP_INST, if_valid <= 0.
  - DELAY_SLOT = 1: load normally.
- imem_rdy = 1 and stall = 0, redirect_pend = 1:
  - Discard imem_data; pc <= pend_target; redirect_pend <= 0; IF/ID <= bubble.
- imem_rdy = 1 and stall = 1:
  - Capture imem_data into the hold buffer; go to HOLD. PC and IF/ID are unchanged.
- imem_rdy = 0:
  - Stay in FETCH; IF/ID unchanged.
  - If a redirect arrives: latch pend_target and set redirect_pend. The in-flight address is not altered.

FSM, HOLD (imem_req = 0):
- While stall = 1, remain in HOLD.
- When stall falls, the buffered word is treated exactly as an imem_rdy = 1 return (same redirect and redirect_pend rules). Return to FETCH.

Stall:
- stall = 1 freezes pc, pc4, inst and if_valid regardless of imem_rdy.
- Redirects are ignored while stall = 1; decode re-presents them.

Simultaneous events:
- A redirect in the same cycle as an existing redirect_pend overwrites pend_target (latest wins).

Reset mid-operation:
- Asserting reset during FETCH-wait or HOLD aborts the outstanding request.
- A late imem_rdy arriving after reset is ignored, because imem_req was 0 during reset.

Latency:
- Zero-wait memory with no stall gives one instruction per cycle. IF/ID updates on the edge where imem_rdy = 1.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- Defined: adds outputs fetch_cnt[31:0] (increments on each IF/ID load with if_valid = 1) and stall_cnt[31:0] (increments on each cycle with stall = 1 or FETCH with imem_rdy = 0).
  - Both counters wrap at 2^32.
  - Both are cleared by reset.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Shared package: the PCSRC_SEQ/BR/RA/JMP 2-bit encodings (shared with the Control_Unit) and NOP_INST.
- Shared package: FSM state typedef (FETCH, HOLD).
- One sub-module: next_pc_mux (pcsource, pc+4, bpc, ra, jpc -> next pc), combinational, reusable by the branch-prediction work.

Test Plan:
- Reset, then zero-wait memory returning 0x11,0x22,0x33 -> imem_addr 0,4,8; pc4 = 4,8,12; inst follows one per cycle; if_valid = 1 from the first load.
- pcsource = 01, bpc = 0x40 on the cycle inst at pc 8 returns, DELAY_SLOT = 0 -> next imem_addr = 0x40; IF/ID = NOP with if_valid = 0 for one cycle, then inst from 0x40 with pc4 = 0x44.
- imem_rdy low for 3 cycles at addr 0x10 -> imem_addr held at 0x10, IF/ID unchanged. On rdy, inst loads with pc4 = 0x14.
- stall = 1 for 2 cycles while imem_rdy = 1 returns 0xAB -> FSM enters HOLD, imem_req = 0, outputs frozen. Stall release -> inst = 0xAB, next addr = pc+4.
- Redirect jpc = 0x100 during a memory wait at 0x20 -> data returned for 0x20 is discarded (if_valid = 0). Next imem_addr = 0x100.
- Reset asserted mid-wait at 0x30 -> imem_req = 0 immediately and if_valid = 0. After release, imem_addr = RESET_PC. With IF_FETCH_STATS_EN defined, both counters read 0.
